// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: operation codes, result classes and multiplier FSM states for the execute stage
package ex_stage_pkg;
  typedef enum logic [2:0] {
    EXE_RES_NOP   = 3'b000,
    EXE_RES_LOGIC = 3'b001,
    EXE_RES_SHIFT = 3'b010,
    EXE_RES_MOVE  = 3'b011,
    EXE_RES_MUL   = 3'b101
  } alusel_e;
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;
  localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operands in, EX/MEM result and stall out
interface ex_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_o;
  modport master (output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, input wd_o, wreg_o, wdata_o, stall_o);
  modport slave (input aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, output wd_o, wreg_o, wdata_o, stall_o);
endinterface

// File: rtl/ex_stage_mul_iter.sv
// mul_iter: N-cycle shift-add multiplier on magnitudes with optional final negation
module mul_iter #(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        neg,
  output logic [63:0] product,
  output logic        done
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  logic [63:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [31:0] mplier_q, mplier_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, neg_q, neg_d;
  always_comb begin
    done = busy_q && cnt_q == LAST;
    busy_d = start || (busy_q && !done);
    neg_d = start ? neg : neg_q;
    mcand_d = start ? {32'b0, a} : busy_q ? mcand_q << 1 : mcand_q;
    mplier_d = start ? b : busy_q ? mplier_q >> 1 : mplier_q;
    acc_d = start ? '0 : (busy_q && mplier_q[0]) ? acc_q + mcand_q : acc_q;
    cnt_d = (start || !busy_q) ? '0 : cnt_q + 1'b1;
    product = neg_q ? -acc_q : acc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      neg_q <= neg_d;
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with logic/shift ALU, HI/LO pair and iterative multiplier stall control
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input logic clk,
  input logic rst,
  ex_stage_if.slave ex
);
  mul_state_e state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] logic_res, shift_res, sra_res, move_res, res, mul_a, mul_b;
  logic [63:0] product;
  logic [4:0] sh;
  logic is_mul, is_mt, signed_op, start, done;
  always_comb begin
    is_mul = ex.alusel_i == EXE_RES_MUL && (ex.aluop_i == EXE_MULT_OP || ex.aluop_i == EXE_MULTU_OP);
    is_mt = ex.alusel_i == EXE_RES_MOVE && (ex.aluop_i == EXE_MTHI_OP || ex.aluop_i == EXE_MTLO_OP);
    signed_op = ex.aluop_i == EXE_MULT_OP;
    start = state_q == MUL_IDLE && is_mul;
    mul_a = signed_op ? mag(ex.reg1_i) : ex.reg1_i;
    mul_b = signed_op ? mag(ex.reg2_i) : ex.reg2_i;
    sh = ex.reg1_i[4:0];
    sra_res = $signed(ex.reg2_i) >>> sh;
    logic_res = ex.aluop_i == EXE_OR_OP  ? ex.reg1_i | ex.reg2_i :
                ex.aluop_i == EXE_AND_OP ? ex.reg1_i & ex.reg2_i :
                ex.aluop_i == EXE_XOR_OP ? ex.reg1_i ^ ex.reg2_i :
                ex.aluop_i == EXE_NOR_OP ? ~(ex.reg1_i | ex.reg2_i) : '0;
    shift_res = ex.aluop_i == EXE_SLL_OP ? ex.reg2_i << sh :
                ex.aluop_i == EXE_SRL_OP ? ex.reg2_i >> sh :
                ex.aluop_i == EXE_SRA_OP ? sra_res : '0;
    move_res = ex.aluop_i == EXE_MFHI_OP ? hi_q : ex.aluop_i == EXE_MFLO_OP ? lo_q : '0;
    res = ex.alusel_i == EXE_RES_LOGIC ? logic_res :
          ex.alusel_i == EXE_RES_SHIFT ? shift_res :
          ex.alusel_i == EXE_RES_MOVE  ? move_res : '0;
    ex.stall_o = !rst && (start || state_q == MUL_BUSY);
    ex.wdata_o = rst ? '0 : res;
    ex.wd_o = rst ? '0 : ex.wd_i;
    ex.wreg_o = !rst && ex.wreg_i && !ex.stall_o && !is_mt && ex.alusel_i != EXE_RES_MUL;
    state_d = state_q == MUL_IDLE ? (is_mul ? MUL_BUSY : MUL_IDLE) :
              state_q == MUL_BUSY ? (done ? MUL_DONE : MUL_BUSY) : MUL_IDLE;
    hi_d = state_q == MUL_DONE ? product[63:32] : (is_mt && ex.aluop_i == EXE_MTHI_OP) ? ex.reg1_i : hi_q;
    lo_d = state_q == MUL_DONE ? product[31:0] : (is_mt && ex.aluop_i == EXE_MTLO_OP) ? ex.reg1_i : lo_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  mul_iter #(.N(MUL_CYCLES)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(mul_a),
    .b(mul_b),
    .neg(signed_op && (ex.reg1_i[31] ^ ex.reg2_i[31])),
    .product(product),
    .done(done)
  );
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: random and directed checks of ex_stage against an arithmetic reference model
module tb_ex_stage;
  import ex_stage_pkg::*;
  typedef struct {logic [7:0] op; logic [2:0] sel;} opd_t;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  opd_t ops [15];
  always #5 clk = ~clk;
  ex_stage_if bus();
  ex_stage #(.MUL_CYCLES(32)) dut (.clk(clk), .rst(rst), .ex(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
    bus.aluop_i = op;
    bus.alusel_i = sel;
    bus.reg1_i = r1;
    bus.reg2_i = r2;
    bus.wd_i = wd;
    bus.wreg_i = wreg;
  endtask
  function automatic logic [31:0] ref_res(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1, input logic [31:0] r2);
    logic [63:0] t;
    t = {{32{r2[31]}}, r2} >> r1[4:0];
    if (sel == EXE_RES_LOGIC)
      return op == EXE_OR_OP ? r1 | r2 : op == EXE_AND_OP ? r1 & r2 : op == EXE_XOR_OP ? r1 ^ r2 : op == EXE_NOR_OP ? ~(r1 | r2) : 32'd0;
    if (sel == EXE_RES_SHIFT)
      return op == EXE_SLL_OP ? r2 << r1[4:0] : op == EXE_SRL_OP ? r2 >> r1[4:0] : op == EXE_SRA_OP ? t[31:0] : 32'd0;
    if (sel == EXE_RES_MOVE)
      return op == EXE_MFHI_OP ? m_hi : op == EXE_MFLO_OP ? m_lo : 32'd0;
    return 32'd0;
  endfunction
  task automatic alu(input string tag, input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
    logic mt;
    mt = sel == EXE_RES_MOVE && (op == EXE_MTHI_OP || op == EXE_MTLO_OP);
    drive(op, sel, r1, r2, wd, wreg);
    @(negedge clk);
    check({tag, "_wdata"}, 64'(bus.wdata_o), 64'(ref_res(op, sel, r1, r2)));
    check({tag, "_wreg"}, 64'(bus.wreg_o), 64'(wreg && !mt));
    check({tag, "_wd"}, 64'(bus.wd_o), 64'(wd));
    check({tag, "_stall"}, 64'(bus.stall_o), 64'd0);
    @(posedge clk);
    if (sel == EXE_RES_MOVE && op == EXE_MTHI_OP) m_hi = r1;
    if (sel == EXE_RES_MOVE && op == EXE_MTLO_OP) m_lo = r1;
    #1;
  endtask
  task automatic mult(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic wr;
    longint sa, sb;
    logic [63:0] p;
    n = 0;
    wr = 1'b0;
    drive(sgn ? EXE_MULT_OP : EXE_MULTU_OP, EXE_RES_MUL, a, b, 5'd9, 1'b1);
    @(negedge clk);
    while (bus.stall_o && n < 100) begin
      n++;
      wr |= bus.wreg_o;
      @(negedge clk);
    end
    wr |= bus.wreg_o;
    check({tag, "_stall_cycles"}, 64'(n), 64'd33);
    check({tag, "_wreg_low"}, 64'(wr), 64'd0);
    @(posedge clk);
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    p = 64'(sa * sb);
    {m_hi, m_lo} = p;
    #1;
  endtask
  initial begin
    ops = '{'{EXE_OR_OP, EXE_RES_LOGIC}, '{EXE_AND_OP, EXE_RES_LOGIC}, '{EXE_XOR_OP, EXE_RES_LOGIC},
            '{EXE_NOR_OP, EXE_RES_LOGIC}, '{EXE_SLL_OP, EXE_RES_SHIFT}, '{EXE_SRL_OP, EXE_RES_SHIFT},
            '{EXE_SRA_OP, EXE_RES_SHIFT}, '{EXE_MFHI_OP, EXE_RES_MOVE}, '{EXE_MFLO_OP, EXE_RES_MOVE},
            '{EXE_MTHI_OP, EXE_RES_MOVE}, '{EXE_MTLO_OP, EXE_RES_MOVE}, '{8'hFF, EXE_RES_LOGIC},
            '{EXE_NOP_OP, EXE_RES_NOP}, '{EXE_MULT_OP, EXE_RES_MUL}, '{EXE_MULTU_OP, EXE_RES_MUL}};
    rst = 1'b1;
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'h1, 5'd7, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wdata", 64'(bus.wdata_o), 64'd0);
    check("rst_wreg", 64'(bus.wreg_o), 64'd0);
    check("rst_wd", 64'(bus.wd_o), 64'd0);
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    alu("or", EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FFFF, 32'h1234_0000, 5'd5, 1'b1);
    alu("sra", EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd1, 1'b1);
    alu("srl", EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd2, 1'b1);
    alu("sll", EXE_SLL_OP, EXE_RES_SHIFT, 32'h24, 32'd1, 5'd3, 1'b1);
    mult("multu", 1'b0, 32'hFFFF_FFFF, 32'd2);
    alu("mfhi_u", EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd4, 1'b1);
    alu("mflo_u", EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd4, 1'b1);
    mult("mult_neg", 1'b1, 32'hFFFF_FFFD, 32'd5);
    alu("mfhi_s", EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd6, 1'b1);
    alu("mflo_s", EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd6, 1'b1);
    alu("mthi", EXE_MTHI_OP, EXE_RES_MOVE, 32'hCAFE_BABE, 32'd0, 5'd8, 1'b1);
    alu("mfhi_mt", EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd8, 1'b1);
    drive(EXE_MULT_OP, EXE_RES_MUL, 32'd7, 32'd9, 5'd3, 1'b1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_stall", 64'(bus.stall_o), 64'd0);
    check("rst_mid_wdata", 64'(bus.wdata_o), 64'd0);
    check("rst_mid_wd", 64'(bus.wd_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("post_rst_stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk);
    #1;
    alu("mfhi_rst", EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
    alu("mflo_rst", EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
    mult("mult_fresh", 1'b1, 32'd7, 32'd9);
    alu("mflo_fresh", EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
    mult("mult_b2b_a", 1'b1, 32'h8000_0000, 32'h8000_0000);
    mult("mult_b2b_b", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
    alu("mfhi_b2b", EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
    alu("mflo_b2b", EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
    for (int i = 0; i < 300; i++) begin
      int k;
      logic [31:0] r1, r2;
      k = $urandom_range(0, 14);
      r1 = $urandom_range(0, 3) == 0 ? 32'h8000_0000 | $urandom_range(0, 7) : $urandom;
      r2 = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF - $urandom_range(0, 7) : $urandom;
      if (ops[k].sel == EXE_RES_MUL) begin
        if ($urandom_range(0, 3) == 0) mult("rnd_mul", ops[k].op == EXE_MULT_OP, r1, r2);
      end else begin
        alu("rnd", ops[k].op, ops[k].sel, r1, r2, 5'($urandom), 1'($urandom));
      end
    end
    alu("mfhi_end", EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
    alu("mflo_end", EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
